// File: rtl/crossbar_nxm_write_arb.sv
// N-requester to M-bank-group write crossbar: per-bank round-robin (or fixed
// lowest-index) arbitration, combinational grants, registered bank outputs.
module crossbar_nxm_write_arb #(
   parameter int N_LSU      = 8,
   parameter int N_BG       = 8,
   parameter int DATA_W     = 32,
   parameter int CNT_W      = 16,
   parameter int FIXED_PRIO = 0,
   localparam int SEL_W     = ($clog2(N_BG) > 1) ? $clog2(N_BG) : 1,
   localparam int SRC_W     = ($clog2(N_LSU) > 1) ? $clog2(N_LSU) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_LSU-1:0]          lsu_wen,
   input  logic [N_LSU*SEL_W-1:0]    lsu_sel,
   input  logic [N_LSU*DATA_W-1:0]   lsu_wdata,
   output logic [N_LSU-1:0]          lsu_gnt,
   output logic [N_BG-1:0]           bg_wen,
   output logic [N_BG*DATA_W-1:0]    bg_wdata,
   output logic [N_BG*SRC_W-1:0]     bg_src,
   input  logic                      cnt_clr,
   output logic [CNT_W-1:0]          conflict_cnt,
   output logic                      sel_err
);

   localparam int               LIM_W      = SEL_W + 1;
   localparam logic [LIM_W-1:0] BANK_LIMIT = LIM_W'(N_BG);
   localparam logic [SRC_W-1:0] LAST_SRC   = SRC_W'(N_LSU - 1);

   logic [SEL_W-1:0]  req_sel  [N_LSU];
   logic [DATA_W-1:0] req_data [N_LSU];
   logic [N_LSU-1:0]  req_oor;
   logic [N_LSU-1:0]  req_inr;
   logic [N_LSU-1:0]  bank_req [N_BG];

   logic [SRC_W-1:0]  ptr_q    [N_BG];
   logic [N_BG-1:0]   bank_hit;
   logic [SRC_W-1:0]  bank_win [N_BG];
   logic [SRC_W-1:0]  next_ptr [N_BG];
   logic [DATA_W-1:0] win_data [N_BG];
   logic              conflict;

   for (genvar i = 0; i < N_LSU; i++) begin : g_unpack
      assign req_sel[i]  = lsu_sel[i*SEL_W +: SEL_W];
      assign req_data[i] = lsu_wdata[i*DATA_W +: DATA_W];
      assign req_oor[i]  = lsu_wen[i] && ({1'b0, req_sel[i]} >= BANK_LIMIT);
      assign req_inr[i]  = lsu_wen[i] && !req_oor[i];
   end

   for (genvar b = 0; b < N_BG; b++) begin : g_bank_req
      for (genvar i = 0; i < N_LSU; i++) begin : g_lsu
         assign bank_req[b][i] = req_inr[i] && (req_sel[i] == SEL_W'(b));
      end
   end

   // Rotating scan per bank: first requester at or after the bank pointer wins.
   always_comb begin
      int idx;
      idx = 0;
      for (int b = 0; b < N_BG; b++) begin
         bank_hit[b] = 1'b0;
         bank_win[b] = '0;
         for (int k = 0; k < N_LSU; k++) begin
            idx = int'(ptr_q[b]) + k;
            if (idx >= N_LSU) begin
               idx = idx - N_LSU;
            end
            if (!bank_hit[b] && bank_req[b][idx]) begin
               bank_hit[b] = 1'b1;
               bank_win[b] = SRC_W'(idx);
            end
         end
      end
   end

   always_comb begin
      for (int b = 0; b < N_BG; b++) begin
         next_ptr[b] = (bank_win[b] == LAST_SRC) ? '0 : bank_win[b] + 1'b1;
         win_data[b] = req_data[bank_win[b]];
      end
   end

   // Out-of-range requests are consumed immediately so the requester never hangs.
   always_comb begin
      lsu_gnt = req_oor;
      for (int b = 0; b < N_BG; b++) begin
         if (bank_hit[b]) begin
            lsu_gnt[bank_win[b]] = 1'b1;
         end
      end
   end

   assign conflict = |(req_inr & ~lsu_gnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bg_wen   <= '0;
         bg_wdata <= '0;
         bg_src   <= '0;
         for (int b = 0; b < N_BG; b++) begin
            ptr_q[b] <= '0;
         end
      end else begin
         bg_wen <= bank_hit;
         for (int b = 0; b < N_BG; b++) begin
            if (bank_hit[b]) begin
               bg_wdata[b*DATA_W +: DATA_W] <= win_data[b];
               bg_src[b*SRC_W +: SRC_W]     <= bank_win[b];
               if (FIXED_PRIO == 0) begin
                  ptr_q[b] <= next_ptr[b];
               end
            end
         end
      end
   end

   // Clear wins over a same-cycle increment; the count sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt <= '0;
      end else if (cnt_clr) begin
         conflict_cnt <= '0;
      end else if (conflict && (conflict_cnt != '1)) begin
         conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err <= 1'b0;
      end else if (|req_oor) begin
         sel_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_crossbar_nxm_write_arb.sv
// Bench for crossbar_nxm_write_arb: a round-robin and a fixed-priority instance,
// each checked against a behavioural model under directed and random traffic.
module tb_crossbar_nxm_write_arb;

   localparam int NL      = 8;
   localparam int NB      = 6;
   localparam int DW      = 8;
   localparam int CW      = 4;
   localparam int SW      = 3;
   localparam int RW      = 3;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [NL-1:0]    wen_v   [2];
   logic [NL*SW-1:0] sel_v   [2];
   logic [NL*DW-1:0] wdata_v [2];
   logic             clr_v   [2];

   logic [NL-1:0]    gnt_o    [2];
   logic [NB-1:0]    bgwen_o  [2];
   logic [NB*DW-1:0] bgdata_o [2];
   logic [NB*RW-1:0] bgsrc_o  [2];
   logic [CW-1:0]    cnt_o    [2];
   logic             err_o    [2];

   int total = 0;
   int bad   = 0;

   // Reference state: index 0 is round-robin, index 1 is fixed priority.
   int            ptr_m    [2][NB];
   int            cnt_m    [2];
   bit            err_m    [2];
   logic [NB-1:0] bgwen_m  [2];
   logic [DW-1:0] bgdata_m [2][NB];
   int            bgsrc_m  [2][NB];
   logic [NL-1:0] gnt_m    [2];

   logic [7:0] rr_gnt_seq [4] = '{8'h01, 8'h08, 8'h80, 8'h01};
   int         rr_src_seq [4] = '{0, 3, 7, 0};

   always #5 clk = ~clk;

   crossbar_nxm_write_arb #(.N_LSU(NL), .N_BG(NB), .DATA_W(DW), .CNT_W(CW), .FIXED_PRIO(0)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .lsu_wen(wen_v[0]), .lsu_sel(sel_v[0]), .lsu_wdata(wdata_v[0]), .lsu_gnt(gnt_o[0]),
      .bg_wen(bgwen_o[0]), .bg_wdata(bgdata_o[0]), .bg_src(bgsrc_o[0]),
      .cnt_clr(clr_v[0]), .conflict_cnt(cnt_o[0]), .sel_err(err_o[0])
   );

   crossbar_nxm_write_arb #(.N_LSU(NL), .N_BG(NB), .DATA_W(DW), .CNT_W(CW), .FIXED_PRIO(1)) u_fixed (
      .clk(clk), .rst_n(rst_n),
      .lsu_wen(wen_v[1]), .lsu_sel(sel_v[1]), .lsu_wdata(wdata_v[1]), .lsu_gnt(gnt_o[1]),
      .bg_wen(bgwen_o[1]), .bg_wdata(bgdata_o[1]), .bg_src(bgsrc_o[1]),
      .cnt_clr(clr_v[1]), .conflict_cnt(cnt_o[1]), .sel_err(err_o[1])
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int selOf(input int d, input int i);
      return int'(sel_v[d][i*SW +: SW]);
   endfunction

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         cnt_m[d]   = 0;
         err_m[d]   = 1'b0;
         bgwen_m[d] = '0;
         gnt_m[d]   = '0;
         for (int b = 0; b < NB; b++) begin
            ptr_m[d][b]    = 0;
            bgdata_m[d][b] = '0;
            bgsrc_m[d][b]  = 0;
         end
      end
   endtask

   // Predicts this cycle's grants and advances the reference to the post-edge state.
   task automatic modelEval(input int d);
      bit            hit [NB];
      int            win [NB];
      logic [NL-1:0] g;
      bit            conf;
      int            idx;
      g    = '0;
      conf = 1'b0;
      for (int b = 0; b < NB; b++) begin
         hit[b] = 1'b0;
         win[b] = 0;
         for (int k = 0; k < NL; k++) begin
            idx = (ptr_m[d][b] + k) % NL;
            if (!hit[b] && wen_v[d][idx] && selOf(d, idx) == b) begin
               hit[b] = 1'b1;
               win[b] = idx;
            end
         end
         if (hit[b]) g[win[b]] = 1'b1;
      end
      for (int i = 0; i < NL; i++) begin
         if (wen_v[d][i] && selOf(d, i) >= NB) begin
            g[i]     = 1'b1;
            err_m[d] = 1'b1;
         end
         if (wen_v[d][i] && selOf(d, i) < NB && !g[i]) conf = 1'b1;
      end
      gnt_m[d] = g;
      for (int b = 0; b < NB; b++) begin
         bgwen_m[d][b] = hit[b];
         if (hit[b]) begin
            bgdata_m[d][b] = wdata_v[d][win[b]*DW +: DW];
            bgsrc_m[d][b]  = win[b];
            ptr_m[d][b]    = (d == 1) ? 0 : (win[b] + 1) % NL;
         end
      end
      if (clr_v[d]) cnt_m[d] = 0;
      else if (conf && cnt_m[d] < CNT_MAX) cnt_m[d] = cnt_m[d] + 1;
   endtask

   task automatic checkRegs(input int d);
      logic [NB*DW-1:0] ed;
      logic [NB*RW-1:0] es;
      for (int b = 0; b < NB; b++) begin
         ed[b*DW +: DW] = bgdata_m[d][b];
         es[b*RW +: RW] = RW'(bgsrc_m[d][b]);
      end
      checkOutput($sformatf("bg_wen[%0d]", d),   64'(bgwen_o[d]),  64'(bgwen_m[d]));
      checkOutput($sformatf("bg_wdata[%0d]", d), 64'(bgdata_o[d]), 64'(ed));
      checkOutput($sformatf("bg_src[%0d]", d),   64'(bgsrc_o[d]),  64'(es));
      checkOutput($sformatf("cnt[%0d]", d),      64'(cnt_o[d]),    64'(cnt_m[d]));
      checkOutput($sformatf("sel_err[%0d]", d),  64'(err_o[d]),    64'(err_m[d]));
   endtask

   task automatic checkResetState(input string tag);
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("%s_wen[%0d]", tag, d),   64'(bgwen_o[d]),  64'd0);
         checkOutput($sformatf("%s_wdata[%0d]", tag, d), 64'(bgdata_o[d]), 64'd0);
         checkOutput($sformatf("%s_src[%0d]", tag, d),   64'(bgsrc_o[d]),  64'd0);
         checkOutput($sformatf("%s_cnt[%0d]", tag, d),   64'(cnt_o[d]),    64'd0);
         checkOutput($sformatf("%s_err[%0d]", tag, d),   64'(err_o[d]),    64'd0);
      end
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic cycleCheck();
      #1;
      for (int d = 0; d < 2; d++) begin
         modelEval(d);
         checkOutput($sformatf("gnt[%0d]", d), 64'(gnt_o[d]), 64'(gnt_m[d]));
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) checkRegs(d);
   endtask

   task automatic clearReqs();
      for (int d = 0; d < 2; d++) begin
         wen_v[d]   = '0;
         sel_v[d]   = '0;
         wdata_v[d] = '0;
         clr_v[d]   = 1'b0;
      end
   endtask

   task automatic driveReq(input int d, input int i, input int sel, input logic [DW-1:0] data);
      wen_v[d][i]             = 1'b1;
      sel_v[d][i*SW +: SW]    = SW'(sel);
      wdata_v[d][i*DW +: DW]  = data;
   endtask

   task automatic driveStall();
      clearReqs();
      for (int d = 0; d < 2; d++) begin
         driveReq(d, 0, 2, 8'h30);
         driveReq(d, 3, 2, 8'h33);
         driveReq(d, 7, 2, 8'h37);
      end
   endtask

   // Ungranted requests hold; granted or idle requesters draw a fresh request.
   task automatic applyStimulus();
      int r;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < NL; i++) begin
            if (!wen_v[d][i] || gnt_m[d][i]) begin
               r = $urandom_range(0, 15);
               wen_v[d][i] = ($urandom_range(0, 9) < 7);
               if (r == 0)      sel_v[d][i*SW +: SW] = SW'(6 + $urandom_range(0, 1));
               else if (r < 10) sel_v[d][i*SW +: SW] = SW'($urandom_range(0, 2));
               else             sel_v[d][i*SW +: SW] = SW'($urandom_range(0, 5));
               wdata_v[d][i*DW +: DW] = DW'($urandom);
            end
         end
         clr_v[d] = ($urandom_range(0, 31) == 0);
      end
   endtask

   initial begin
      clearReqs();
      modelReset();
      #2;
      checkResetState("rst0");
      for (int d = 0; d < 2; d++) checkOutput($sformatf("rst0_gnt[%0d]", d), 64'(gnt_o[d]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Three requesters contending for bank 2.
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         driveStall();
         #1;
         for (int d = 0; d < 2; d++)
            checkOutput($sformatf("fair_gnt%0d[%0d]", c, d), 64'(gnt_o[d]),
                        (d == 0) ? 64'(rr_gnt_seq[c]) : 64'h01);
         cycleCheck();
         for (int d = 0; d < 2; d++)
            checkOutput($sformatf("fair_src%0d[%0d]", c, d), 64'(bgsrc_o[d][2*RW +: RW]),
                        (d == 0) ? 64'(rr_src_seq[c]) : 64'd0);
      end

      // Every bank targeted by a distinct requester.
      @(negedge clk);
      clearReqs();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < NB; i++) driveReq(d, i, i, DW'(8'hA0 + i));
      #1;
      for (int d = 0; d < 2; d++) checkOutput($sformatf("nocont_gnt[%0d]", d), 64'(gnt_o[d]), 64'h3F);
      cycleCheck();
      for (int d = 0; d < 2; d++) checkOutput($sformatf("nocont_wen[%0d]", d), 64'(bgwen_o[d]), 64'h3F);

      // Out-of-range bank select.
      @(negedge clk);
      clearReqs();
      for (int d = 0; d < 2; d++) driveReq(d, 1, 7, 8'h55);
      #1;
      for (int d = 0; d < 2; d++) checkOutput($sformatf("oor_gnt[%0d]", d), 64'(gnt_o[d]), 64'h02);
      cycleCheck();
      @(negedge clk);
      clearReqs();
      cycleCheck();
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("oor_wen[%0d]", d), 64'(bgwen_o[d]), 64'd0);
         checkOutput($sformatf("oor_sticky[%0d]", d), 64'(err_o[d]), 64'd1);
      end

      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         applyStimulus();
         cycleCheck();
      end

      // Saturation then clear coinciding with a conflict.
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         clearReqs();
         for (int d = 0; d < 2; d++) begin
            driveReq(d, 0, 0, 8'h11);
            driveReq(d, 1, 0, 8'h22);
         end
         cycleCheck();
      end
      for (int d = 0; d < 2; d++) checkOutput($sformatf("sat_cnt[%0d]", d), 64'(cnt_o[d]), 64'(CNT_MAX));
      @(negedge clk);
      for (int d = 0; d < 2; d++) clr_v[d] = 1'b1;
      cycleCheck();
      for (int d = 0; d < 2; d++) checkOutput($sformatf("clr_cnt[%0d]", d), 64'(cnt_o[d]), 64'd0);

      // Asynchronous reset in the middle of a stall, with requests kept asserted.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         driveStall();
         cycleCheck();
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkResetState("midrst");
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) checkOutput($sformatf("midrst_gnt[%0d]", d), 64'(gnt_o[d]), 64'h01);
      cycleCheck();

      for (int n = 0; n < 150; n++) begin
         @(negedge clk);
         applyStimulus();
         cycleCheck();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
